// File: rtl/muntjac_metadata_pkg.sv
// -----------------------------------------------------------------------------
// muntjac_metadata_pkg
//
// Shared types and constants for the Muntjac metadata state-machine unit.
//   meta_event_e        : event codes carried on evt_event_i / tbl_event_i
//   meta_resp_state_e   : occupancy of the single-entry response register
//   META_EXC_STATE      : default state that raises the exception flag
//   meta_default_next() : reset / constant contents of the transition table
//
// The optional runtime-writable table is enabled by defining
// MUNTJAC_META_TABLE_WRITE_EN (see muntjac_metadata_table_ram).
// -----------------------------------------------------------------------------
package muntjac_metadata_pkg;

    typedef enum logic [1:0] {
        META_LOAD  = 2'd0,
        META_STORE = 2'd1,
        META_UEVT0 = 2'd2,
        META_UEVT1 = 2'd3
    } meta_event_e;

    typedef enum logic {
        RESP_EMPTY = 1'b0,
        RESP_FULL  = 1'b1
    } meta_resp_state_e;

    localparam int META_EXC_STATE = 1;

    // Default mapping is the identity, except that a uevt0 seen in state 0
    // moves the slot to state 1 (the default exception state).
    function automatic int meta_default_next(input int evt, input int state);
        if ((evt == int'(META_UEVT0)) && (state == 0)) begin
            return 1;
        end
        return state;
    endfunction

endpackage : muntjac_metadata_pkg

// File: rtl/muntjac_metadata_table_ram.sv
// -----------------------------------------------------------------------------
// muntjac_metadata_table_ram
//
// Transition table for the metadata unit: next = table[event][state].
// One combinational read port and one synchronous write port.
//
// Configuration macro: MUNTJAC_META_TABLE_WRITE_EN
//   defined   : table is a register array, reset to meta_default_next(),
//               written through the i_we / i_wr_* port.
//   undefined : table is the constant default mapping; the write port and
//               clock/reset are ignored and no storage is generated.
//
// Ports:
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_we              : table entry write enable
//   i_wr_event        : row (event code) written
//   i_wr_state        : column (current state) written; >= NumStates ignored
//   i_wr_next         : next-state value written
//   i_rd_event        : row read
//   i_rd_state        : column read; out-of-range columns return i_rd_state
//   o_rd_next         : table contents at [i_rd_event][i_rd_state]
// -----------------------------------------------------------------------------
module muntjac_metadata_table_ram
    import muntjac_metadata_pkg::*;
#(
    parameter int NumStates = 4,
    parameter int NumEvents = 4,
    parameter int StateW    = 8,
    parameter int EventW    = (NumEvents > 1) ? $clog2(NumEvents) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [EventW-1:0] i_wr_event,
    input  logic [StateW-1:0] i_wr_state,
    input  logic [StateW-1:0] i_wr_next,
    input  logic [EventW-1:0] i_rd_event,
    input  logic [StateW-1:0] i_rd_state,
    output logic [StateW-1:0] o_rd_next
);

    localparam int SIdxW = (NumStates > 1) ? $clog2(NumStates) : 1;

    logic w_rd_in_range;

    assign w_rd_in_range = (int'(i_rd_state) < NumStates) && (int'(i_rd_event) < NumEvents);

`ifdef MUNTJAC_META_TABLE_WRITE_EN

    logic [StateW-1:0] r_table [NumEvents][NumStates];
    logic [SIdxW-1:0]  w_rd_sidx;
    logic [SIdxW-1:0]  w_wr_sidx;
    logic              w_wr_ok;

    assign w_rd_sidx = i_rd_state[SIdxW-1:0];
    assign w_wr_sidx = i_wr_state[SIdxW-1:0];

    // Columns beyond NumStates do not exist; dropping such writes keeps the
    // truncated index from aliasing onto a legal column.
    assign w_wr_ok = i_we && (int'(i_wr_state) < NumStates) && (int'(i_wr_event) < NumEvents);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int e = 0; e < NumEvents; e++) begin
                for (int s = 0; s < NumStates; s++) begin
                    r_table[e][s] <= StateW'(meta_default_next(e, s));
                end
            end
        end else if (w_wr_ok) begin
            r_table[i_wr_event][w_wr_sidx] <= i_wr_next;
        end
    end

    // Read reflects the table before any write landing at this edge, so an
    // event accepted together with a table write sees the old entry.
    always_comb begin
        o_rd_next = i_rd_state;
        if (w_rd_in_range) begin
            o_rd_next = r_table[i_rd_event][w_rd_sidx];
        end
    end

`else

    logic w_unused_tbl;

    assign w_unused_tbl = ^{i_clk, i_rst, i_we, i_wr_event, i_wr_state, i_wr_next};

    always_comb begin
        o_rd_next = i_rd_state;
        if (w_rd_in_range) begin
            o_rd_next = StateW'(meta_default_next(int'(i_rd_event), int'(i_rd_state)));
        end
    end

`endif

endmodule : muntjac_metadata_table_ram

// File: rtl/muntjac_metadata_fsm.sv
// -----------------------------------------------------------------------------
// muntjac_metadata_fsm
//
// Multi-slot programmable metadata state machine. Each of NumTags slots holds
// a state; an accepted event looks up table[event][slot] to get the next
// state, updates the slot at the edge and loads a registered response.
//
// Configuration macro: MUNTJAC_META_TABLE_WRITE_EN enables the runtime
// writable table (tbl_* port); without it the tbl_* inputs are ignored.
//
// Handshake: evt_* is accepted on evt_valid_i && evt_ready_o. resp_* is a
// single registered entry, valid while resp_valid_o is high, consumed on
// resp_valid_o && resp_ready_i, and held stable while not consumed. A new
// event may be accepted in the same cycle the current response is consumed.
//
// Ports:
//   clk_i, rst_i           : clock, synchronous active-high reset
//   evt_valid_i/ready_o    : event request handshake
//   evt_tag_i, evt_event_i : slot and event code of the request
//   resp_valid_o/ready_i   : response handshake
//   resp_tag_o             : slot of the response
//   resp_prev_o/state_o    : slot state before / after the transition
//   resp_exception_o       : ExcState entered, or illegal current state
//   st_we_i/tag_i/wdata_i  : software slot write (stalls events that cycle)
//   tbl_we_i/event_i/state_i/next_i : transition-table entry write
// -----------------------------------------------------------------------------
module muntjac_metadata_fsm
    import muntjac_metadata_pkg::*;
#(
    parameter int NumStates = 4,
    parameter int NumEvents = 4,
    parameter int NumTags   = 8,
    parameter int StateW    = 8,
    parameter int ExcState  = META_EXC_STATE
) (
    input  logic                         clk_i,
    input  logic                         rst_i,

    input  logic                         evt_valid_i,
    output logic                         evt_ready_o,
    input  logic [$clog2(NumTags)-1:0]   evt_tag_i,
    input  logic [$clog2(NumEvents)-1:0] evt_event_i,

    output logic                         resp_valid_o,
    input  logic                         resp_ready_i,
    output logic [$clog2(NumTags)-1:0]   resp_tag_o,
    output logic [StateW-1:0]            resp_prev_o,
    output logic [StateW-1:0]            resp_state_o,
    output logic                         resp_exception_o,

    input  logic                         st_we_i,
    input  logic [$clog2(NumTags)-1:0]   st_tag_i,
    input  logic [StateW-1:0]            st_wdata_i,

    input  logic                         tbl_we_i,
    input  logic [$clog2(NumEvents)-1:0] tbl_event_i,
    input  logic [StateW-1:0]            tbl_state_i,
    input  logic [StateW-1:0]            tbl_next_i
);

    localparam int TagW   = $clog2(NumTags);
    localparam int EventW = $clog2(NumEvents);

    // -------------------------------------------------------------------------
    // Slot register file and transition lookup
    // -------------------------------------------------------------------------
    logic [StateW-1:0] r_slot [NumTags];

    logic [StateW-1:0] w_prev;
    logic [StateW-1:0] w_tbl_next;
    logic [StateW-1:0] w_next;
    logic              w_illegal;
    logic              w_exc;
    logic              w_ready;
    logic              w_accept;

    // Reading the registered slot is enough for back-to-back events on one
    // slot: the previous update has already landed at the edge in between.
    assign w_prev = r_slot[evt_tag_i];

    muntjac_metadata_table_ram #(
        .NumStates (NumStates),
        .NumEvents (NumEvents),
        .StateW    (StateW),
        .EventW    (EventW)
    ) u_table (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_we       (tbl_we_i),
        .i_wr_event (tbl_event_i),
        .i_wr_state (tbl_state_i),
        .i_wr_next  (tbl_next_i),
        .i_rd_event (evt_event_i),
        .i_rd_state (w_prev),
        .o_rd_next  (w_tbl_next)
    );

    // A slot can only hold an out-of-range state after a software write; such
    // a slot is left untouched and the response flags the exception.
    assign w_illegal = (int'(w_prev) >= NumStates);
    assign w_next    = w_illegal ? w_prev : w_tbl_next;
    assign w_exc     = w_illegal || (w_next == StateW'(ExcState));

    // Software writes own the slot file for their cycle, so events wait.
    assign w_ready  = (!resp_valid_o || resp_ready_i) && !st_we_i;
    assign w_accept = evt_valid_i && w_ready;

    assign evt_ready_o = w_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int t = 0; t < NumTags; t++) begin
                r_slot[t] <= '0;
            end
        end else if (st_we_i) begin
            r_slot[st_tag_i] <= st_wdata_i;
        end else if (w_accept) begin
            r_slot[evt_tag_i] <= w_next;
        end
    end

    // -------------------------------------------------------------------------
    // Response register: occupancy FSM plus payload
    // -------------------------------------------------------------------------
    meta_resp_state_e r_resp_state;
    meta_resp_state_e w_resp_state_next;

    logic [TagW-1:0]   r_resp_tag;
    logic [StateW-1:0] r_resp_prev;
    logic [StateW-1:0] r_resp_state_val;
    logic              r_resp_exc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_resp_state <= RESP_EMPTY;
        end else begin
            r_resp_state <= w_resp_state_next;
        end
    end

    always_comb begin
        w_resp_state_next = r_resp_state;
        case (r_resp_state)
            RESP_EMPTY: begin
                if (w_accept) begin
                    w_resp_state_next = RESP_FULL;
                end
            end
            RESP_FULL: begin
                // Consumed and refilled in one cycle stays FULL.
                if (w_accept) begin
                    w_resp_state_next = RESP_FULL;
                end else if (resp_ready_i) begin
                    w_resp_state_next = RESP_EMPTY;
                end
            end
            default: w_resp_state_next = RESP_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_resp_tag       <= '0;
            r_resp_prev      <= '0;
            r_resp_state_val <= '0;
            r_resp_exc       <= 1'b0;
        end else if (w_accept) begin
            r_resp_tag       <= evt_tag_i;
            r_resp_prev      <= w_prev;
            r_resp_state_val <= w_next;
            r_resp_exc       <= w_exc;
        end
    end

    assign resp_valid_o     = (r_resp_state == RESP_FULL);
    assign resp_tag_o       = r_resp_tag;
    assign resp_prev_o      = r_resp_prev;
    assign resp_state_o     = r_resp_state_val;
    assign resp_exception_o = r_resp_exc;

endmodule : muntjac_metadata_fsm

// File: tb/tb_muntjac_metadata_fsm.sv
// -----------------------------------------------------------------------------
// tb_muntjac_metadata_fsm
//
// Self-checking bench for muntjac_metadata_fsm with default parameters.
// A reference model of the slots and transition table produces the expected
// response for every accepted event; a monitor pops and compares each
// response as it is handed off. Table-write expectations follow
// MUNTJAC_META_TABLE_WRITE_EN as seen by this compilation.
// -----------------------------------------------------------------------------
module tb_muntjac_metadata_fsm;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       evt_valid_i;
    logic       evt_ready_o;
    logic [2:0] evt_tag_i;
    logic [1:0] evt_event_i;
    logic       resp_valid_o;
    logic       resp_ready_i;
    logic [2:0] resp_tag_o;
    logic [7:0] resp_prev_o;
    logic [7:0] resp_state_o;
    logic       resp_exception_o;
    logic       st_we_i;
    logic [2:0] st_tag_i;
    logic [7:0] st_wdata_i;
    logic       tbl_we_i;
    logic [1:0] tbl_event_i;
    logic [7:0] tbl_state_i;
    logic [7:0] tbl_next_i;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [19:0] exp_q[$];
    logic [19:0] mon_got;
    logic [19:0] mon_exp;

    logic [7:0] m_slot [8];
    logic [7:0] m_tbl  [4][4];

    // ---------------------------------------------------------------- clock
    always #5 clk = ~clk;

    muntjac_metadata_fsm dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .evt_valid_i      (evt_valid_i),
        .evt_ready_o      (evt_ready_o),
        .evt_tag_i        (evt_tag_i),
        .evt_event_i      (evt_event_i),
        .resp_valid_o     (resp_valid_o),
        .resp_ready_i     (resp_ready_i),
        .resp_tag_o       (resp_tag_o),
        .resp_prev_o      (resp_prev_o),
        .resp_state_o     (resp_state_o),
        .resp_exception_o (resp_exception_o),
        .st_we_i          (st_we_i),
        .st_tag_i         (st_tag_i),
        .st_wdata_i       (st_wdata_i),
        .tbl_we_i         (tbl_we_i),
        .tbl_event_i      (tbl_event_i),
        .tbl_state_i      (tbl_state_i),
        .tbl_next_i       (tbl_next_i)
    );

    // ---------------------------------------------------------------- model
    function automatic void model_reset();
        for (int t = 0; t < 8; t++) m_slot[t] = 8'd0;
        for (int e = 0; e < 4; e++) begin
            for (int s = 0; s < 4; s++) begin
                m_tbl[e][s] = ((e == 2) && (s == 0)) ? 8'd1 : 8'(s);
            end
        end
    endfunction

    function automatic logic [19:0] model_evt(input int tag, input int ev);
        logic [7:0] p;
        logic [7:0] n;
        logic       e;
        p = m_slot[tag];
        if (p >= 8'd4) begin
            n = p;
            e = 1'b1;
        end else begin
            n = m_tbl[ev][p[1:0]];
            e = (n == 8'd1);
        end
        m_slot[tag] = n;
        return {3'(tag), p, n, e};
    endfunction

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (!rst_i && resp_valid_o && resp_ready_i) begin
            mon_got = {resp_tag_o, resp_prev_o, resp_state_o, resp_exception_o};
            chk_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL resp_unexpected got tag=%0d prev=%0d state=%0d exc=%0d required no response",
                         resp_tag_o, resp_prev_o, resp_state_o, resp_exception_o);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp)
                    $display("FAIL resp_scoreboard got tag=%0d prev=%0d state=%0d exc=%0d required tag=%0d prev=%0d state=%0d exc=%0d",
                             mon_got[19:17], mon_got[16:9], mon_got[8:1], mon_got[0],
                             mon_exp[19:17], mon_exp[16:9], mon_exp[8:1], mon_exp[0]);
                else
                    pass_cnt++;
            end
        end
    end

    // ---------------------------------------------------------------- drivers
    // Presents an event and holds it until accepted; the expected response is
    // queued for the edge on which the event is taken.
    task automatic drive_evt(input int tag, input int ev, input bit rnd_ready);
        bit done;
        int tries;
        evt_valid_i = 1'b1;
        evt_tag_i   = 3'(tag);
        evt_event_i = 2'(ev);
        done  = 1'b0;
        tries = 0;
        while (!done && tries < 20) begin
            if (rnd_ready) resp_ready_i = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (evt_ready_o === 1'b1) begin
                exp_q.push_back(model_evt(tag, ev));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            tries++;
        end
        evt_valid_i = 1'b0;
        if (!done) begin
            chk_cnt++;
            $display("FAIL evt_accept_timeout tag=%0d ev=%0d got no accept in 20 cycles required accept", tag, ev);
        end
    endtask

    task automatic idle(input int n);
        resp_ready_i = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst_i = 1'b1; evt_valid_i = 1'b0; evt_tag_i = '0; evt_event_i = '0;
        resp_ready_i = 1'b1; st_we_i = 1'b0; st_tag_i = '0; st_wdata_i = '0;
        tbl_we_i = 1'b0; tbl_event_i = '0; tbl_state_i = '0; tbl_next_i = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        model_reset();
        chk_cnt++; if (resp_valid_o !== 1'b0) $display("FAIL reset_valid got %0b required 0", resp_valid_o); else pass_cnt++;
        chk_cnt++; if (resp_exception_o !== 1'b0) $display("FAIL reset_exc got %0b required 0", resp_exception_o); else pass_cnt++;
        chk_cnt++; if (resp_tag_o !== 3'd0) $display("FAIL reset_tag got %0d required 0", resp_tag_o); else pass_cnt++;
        chk_cnt++; if (resp_prev_o !== 8'd0) $display("FAIL reset_prev got %0d required 0", resp_prev_o); else pass_cnt++;
        chk_cnt++; if (resp_state_o !== 8'd0) $display("FAIL reset_state got %0d required 0", resp_state_o); else pass_cnt++;
        chk_cnt++; if (evt_ready_o !== 1'b1) $display("FAIL reset_ready got %0b required 1", evt_ready_o); else pass_cnt++;
    endtask

    task automatic test_uevt0();
        drive_evt(3, 2, 1'b0);
        chk_cnt++; if (resp_valid_o !== 1'b1) $display("FAIL uevt0_latency got valid=%0b required 1", resp_valid_o); else pass_cnt++;
        chk_cnt++; if ({resp_tag_o, resp_prev_o, resp_state_o, resp_exception_o} !== {3'd3, 8'd0, 8'd1, 1'b1})
            $display("FAIL uevt0_resp got tag=%0d prev=%0d state=%0d exc=%0b required tag=3 prev=0 state=1 exc=1",
                     resp_tag_o, resp_prev_o, resp_state_o, resp_exception_o);
        else pass_cnt++;
        @(posedge clk);
        #1;
        chk_cnt++; if (resp_valid_o !== 1'b0) $display("FAIL resp_clear got valid=%0b required 0", resp_valid_o); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            drive_evt(3, i, 1'b0);
            chk_cnt++; if ({resp_valid_o, resp_prev_o, resp_state_o, resp_exception_o} !== {1'b1, 8'd1, 8'd1, 1'b1})
                $display("FAIL b2b_resp%0d got valid=%0b prev=%0d state=%0d exc=%0b required valid=1 prev=1 state=1 exc=1",
                         i, resp_valid_o, resp_prev_o, resp_state_o, resp_exception_o);
            else pass_cnt++;
        end
        idle(2);
    endtask

    task automatic test_resp_hold();
        resp_ready_i = 1'b0;
        drive_evt(6, 3, 1'b0);
        // A competing event is presented but must not be taken while stalled.
        evt_valid_i = 1'b1; evt_tag_i = 3'd7; evt_event_i = 2'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_cnt++; if (evt_ready_o !== 1'b0) $display("FAIL hold_ready%0d got %0b required 0", i, evt_ready_o); else pass_cnt++;
            chk_cnt++; if ({resp_valid_o, resp_tag_o, resp_prev_o, resp_state_o, resp_exception_o} !== {1'b1, 3'd6, 8'd0, 8'd0, 1'b0})
                $display("FAIL hold_resp%0d got valid=%0b tag=%0d prev=%0d state=%0d exc=%0b required valid=1 tag=6 prev=0 state=0 exc=0",
                         i, resp_valid_o, resp_tag_o, resp_prev_o, resp_state_o, resp_exception_o);
            else pass_cnt++;
            @(posedge clk);
            #1;
        end
        evt_valid_i = 1'b0;
        idle(1);
        chk_cnt++; if (resp_valid_o !== 1'b0) $display("FAIL hold_release got valid=%0b required 0", resp_valid_o); else pass_cnt++;
        drive_evt(7, 2, 1'b0);
        chk_cnt++; if ({resp_prev_o, resp_state_o} !== {8'd0, 8'd1})
            $display("FAIL hold_no_side_effect got prev=%0d state=%0d required prev=0 state=1", resp_prev_o, resp_state_o);
        else pass_cnt++;
        idle(2);
    endtask

    task automatic test_reset_mid_op();
        resp_ready_i = 1'b0;
        drive_evt(1, 2, 1'b0);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        exp_q.delete();
        model_reset();
        resp_ready_i = 1'b1;
        chk_cnt++; if ({resp_valid_o, resp_tag_o, resp_state_o, resp_exception_o} !== {1'b0, 3'd0, 8'd0, 1'b0})
            $display("FAIL midreset_resp got valid=%0b tag=%0d state=%0d exc=%0b required all 0",
                     resp_valid_o, resp_tag_o, resp_state_o, resp_exception_o);
        else pass_cnt++;
        chk_cnt++; if (evt_ready_o !== 1'b1) $display("FAIL midreset_ready got %0b required 1", evt_ready_o); else pass_cnt++;
        drive_evt(3, 2, 1'b0);
        chk_cnt++; if (resp_prev_o !== 8'd0) $display("FAIL midreset_slot got prev=%0d required 0", resp_prev_o); else pass_cnt++;
        idle(2);
    endtask

    task automatic test_table_write();
        logic [7:0] exp_second;
        logic [7:0] exp_load;
`ifdef MUNTJAC_META_TABLE_WRITE_EN
        exp_second = 8'd2;
        exp_load   = 8'd3;
`else
        exp_second = 8'd0;
        exp_load   = 8'd0;
`endif
        tbl_we_i = 1'b1; tbl_event_i = 2'd1; tbl_state_i = 8'd0; tbl_next_i = 8'd2;
        drive_evt(0, 1, 1'b0);
        tbl_we_i = 1'b0;
`ifdef MUNTJAC_META_TABLE_WRITE_EN
        m_tbl[1][0] = 8'd2;
`endif
        chk_cnt++; if (resp_state_o !== 8'd0) $display("FAIL tbl_hazard_old got state=%0d required 0", resp_state_o); else pass_cnt++;
        drive_evt(0, 1, 1'b0);
        chk_cnt++; if (resp_state_o !== exp_second) $display("FAIL tbl_new_entry got state=%0d required %0d", resp_state_o, exp_second); else pass_cnt++;
        // table[0][0]=3, then an out-of-range column write that must be dropped.
        tbl_we_i = 1'b1; tbl_event_i = 2'd0; tbl_state_i = 8'd0; tbl_next_i = 8'd3;
        @(posedge clk);
        #1;
        tbl_state_i = 8'd4; tbl_next_i = 8'd1;
        @(posedge clk);
        #1;
        tbl_we_i = 1'b0;
`ifdef MUNTJAC_META_TABLE_WRITE_EN
        m_tbl[0][0] = 8'd3;
`endif
        drive_evt(4, 0, 1'b0);
        chk_cnt++; if (resp_state_o !== exp_load) $display("FAIL tbl_load got state=%0d required %0d", resp_state_o, exp_load); else pass_cnt++;
        idle(2);
    endtask

    task automatic test_sw_write();
        st_we_i = 1'b1; st_tag_i = 3'd5; st_wdata_i = 8'd9;
        evt_valid_i = 1'b1; evt_tag_i = 3'd2; evt_event_i = 2'd0;
        @(negedge clk);
        chk_cnt++; if (evt_ready_o !== 1'b0) $display("FAIL sw_stall got ready=%0b required 0", evt_ready_o); else pass_cnt++;
        @(posedge clk);
        #1;
        st_we_i = 1'b0;
        m_slot[5] = 8'd9;
        drive_evt(2, 0, 1'b0);
        chk_cnt++; if (resp_tag_o !== 3'd2) $display("FAIL sw_stalled_evt got tag=%0d required 2", resp_tag_o); else pass_cnt++;
        drive_evt(5, 0, 1'b0);
        chk_cnt++; if ({resp_prev_o, resp_state_o, resp_exception_o} !== {8'd9, 8'd9, 1'b1})
            $display("FAIL sw_illegal got prev=%0d state=%0d exc=%0b required prev=9 state=9 exc=1",
                     resp_prev_o, resp_state_o, resp_exception_o);
        else pass_cnt++;
        drive_evt(5, 3, 1'b0);
        idle(2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            drive_evt(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1'b1);
        end
        resp_ready_i = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk_cnt++; if (exp_q.size() != 0) $display("FAIL drain got %0d pending required 0", exp_q.size()); else pass_cnt++;
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        test_reset();
        test_uevt0();
        test_back_to_back();
        test_resp_hold();
        test_reset_mid_op();
        test_table_write();
        test_sw_write();
        test_random();
        idle(2);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_muntjac_metadata_fsm

// File: doc/muntjac_metadata_fsm.md
# muntjac_metadata_fsm

Programmable, multi-slot metadata state-machine unit for the Muntjac pipeline. Each of `NumTags` tracked metadata slots holds a current state; incoming events (load, store, user events) are looked up in a runtime-writable transition table to produce the next state. Reaching the exception state raises an exception flag in the registered response. The unit sits beside the memory stage, and software reprograms it through a CSR-side write port.

## Interface
- `NumStates`, default 4: number of legal states; entries `0..NumStates-1`.
- `NumEvents`, default 4: number of event codes; 0=load, 1=store, 2=uevt0, 3=uevt1.
- `NumTags`, default 8: number of independently tracked metadata slots.
- `StateW`, default 8: state encoding width; must satisfy `2**StateW >= NumStates`.
- `ExcState`, default 1: state that signals an exception when entered.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `evt_valid_i` in 1: event request valid.
- `evt_ready_o` out 1: event request accepted when high together with `evt_valid_i`.
- `evt_tag_i` in `$clog2(NumTags)`: slot addressed by the event.
- `evt_event_i` in `$clog2(NumEvents)`: event code.
- `resp_valid_o` out 1: response valid.
- `resp_ready_i` in 1: response consumed.
- `resp_tag_o` out `$clog2(NumTags)`: slot of the response.
- `resp_prev_o` out `StateW`: slot state before the transition.
- `resp_state_o` out `StateW`: slot state after the transition.
- `resp_exception_o` out 1: the transition entered `ExcState`, or the transition was illegal.
- `st_we_i` in 1: software write of a slot state.
- `st_tag_i` in `$clog2(NumTags)`: slot written by software.
- `st_wdata_i` in `StateW`: state value written by software.
- `tbl_we_i` in 1: transition-table entry write (compiled only with the macro).
- `tbl_event_i` in `$clog2(NumEvents)`: table row written.
- `tbl_state_i` in `StateW`: table column written.
- `tbl_next_i` in `StateW`: next-state value written.

## Operation
- **Reset contents**
  - Table resets to the identity mapping, `table[e][s] = s`, with one exception: `table[2][0] = 1`.
  - All slot states reset to 0.
- **Event accept.** An event is accepted on `evt_valid_i && evt_ready_o`. On acceptance:
  - `prev = slot[tag]` is read combinationally.
  - `next = table[event][prev]`.
  - `slot[tag]` is updated to `next` at the clock edge.
  - The response register loads tag, prev, next and exception.
- **Ready rule.** `evt_ready_o = (!resp_valid_o || resp_ready_i) && !st_we_i`.
- **Exception rule.** Exception is set when `next == ExcState`.
- **Illegal transition.** If `prev >= NumStates` (only reachable through a software write), the transition is illegal:
  - `next = prev`, so the slot is unchanged.
  - The exception flag is forced to 1.
- **Software state write**
  - Priority: `st_we_i` has priority over events; events are stalled for that cycle.
  - Effect: the write lands at the edge.
  - Values: any `StateW` value is accepted.
- **Table write hazard.** When a table write and an event are accepted in the same cycle, the event uses the old table entry and the new entry takes effect at the edge.
- **Same-slot back-to-back.** Consecutive events to the same slot see each other's update, with no stall, because the slot read follows the registered state.
- **Table write range.** Table writes with `tbl_state_i >= NumStates` are ignored.

## Timing
- **Latency.** An event accepted in cycle N produces a response in cycle N+1.
- **Throughput.** One event per cycle while `resp_ready_i` stays high.
- **Response hold.** `resp_*` holds stable while `resp_valid_o && !resp_ready_i`.
- **Response clear.** `resp_valid_o` clears on a handshake with no new accept.
- **Reset.** Reset in the middle of an operation drops any pending response. Outputs after reset:
  - `resp_valid_o=0`, `resp_exception_o=0`.
  - `resp_tag_o=0`, `resp_prev_o=0`, `resp_state_o=0`.
  - `evt_ready_o=1` (provided `st_we_i` is low).

## Configuration
- `MUNTJAC_META_TABLE_WRITE_EN`
  - Defined: the table is a register array written through the `tbl_*` port.
  - Undefined: the table is the constant reset mapping, the `tbl_*` inputs are ignored, and no table flops are generated.

## Structure
- **Package `muntjac_metadata_pkg`**
  - `meta_event_e` enum: `META_LOAD`, `META_STORE`, `META_UEVT0`, `META_UEVT1`.
  - `META_EXC_STATE` constant.
  - Default-table function `meta_default_next(event, state)`.
- **Sub-module `muntjac_metadata_table_ram`.** Holds the transition table, with one combinational read port and one write port; the macro selects storage or constant.
- **Top-level contents.** Slot register file, ready logic and response register.

## Test plan
- After reset, send uevt0 to tag 3 → response `prev=0`, `state=1`, `exception=1`, delivered one cycle later.
- Send a load to tag 3, then a store to tag 3 on back-to-back cycles → both responses `prev=1`, `state=1`, `exception=1`, issued in consecutive cycles.
- Hold `resp_ready_i=0` for 3 cycles after one event → `evt_ready_o=0`, response held stable, accepted on release.
- Write `table[1][0]=2` in the same cycle as a store to tag 0 → that response `state=0`; the next store gives `state=2`.
- Set `st_we_i` for tag 5 with value 9 while an event is valid → the event stalls that cycle; a following load to tag 5 gives `prev=9`, `state=9`, `exception=1`.
- Build without the macro, write `table[0][0]=3`, then send a load → `state=0`; the write had no effect.
